// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program memory: FSM states, opcodes and the
// built-in boot image (cells past the 16-word image read as zero).
package prog_mem_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_NOP = 4'hC;
  localparam logic [3:0] OP_LDI = 4'hD;
  localparam logic [3:0] OP_RST = 4'hE;

  localparam int IMAGE_WORDS = 16;

  function automatic logic [11:0] image_word(input int unsigned idx);
    logic [11:0] w;
    w = 12'h000;
    case (idx)
      0:       w = {OP_NOP, 8'h00};
      1:       w = {OP_LDI, 8'h20};
      2, 3:    w = {OP_INC, 8'h00};
      4:       w = {OP_ST,  8'h00};
      5, 6:    w = {OP_INC, 8'h00};
      7:       w = {OP_ADD, 8'h00};
      8, 9:    w = {OP_INC, 8'h00};
      10:      w = {OP_LD,  8'h00};
      11:      w = {OP_ADD, 8'h00};
      12, 13:  w = {OP_INC, 8'h00};
      14:      w = {OP_RST, 8'h00};
      15:      w = {OP_NOP, 8'h00};
      default: w = 12'h000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/prog_mem_array.sv
// 1-write/1-read synchronous storage; a read and write to the same cell on one
// edge returns the old word. The read register clears on reset.
module prog_mem_array #(
  parameter int WIDTH      = 12,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem.sv
// Program memory top: boot-image init sequencer, one-deep fetch output stage and
// optional run-time loader (enabled by defining PROG_MEM_LOADER_EN).
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  gnt_o,
  output logic                  valid_o,
  output logic [WIDTH-1:0]      data_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  input  logic                  ld_we_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [WIDTH-1:0]      ld_data_i,
  output logic                  ld_err_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic                    ld_err_q, ld_err_d;
  logic                    gnt, accept, ld_wr, we;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [WIDTH-1:0]        wdata;

`ifdef PROG_MEM_LOADER_EN
  assign ld_wr    = ld_we_i && rst_ni && (state_q == S_RUN);
  assign ld_err_d = ld_we_i && (!rst_ni || (state_q == S_INIT));
`else
  logic unused_ld;
  assign unused_ld = ^{ld_we_i, ld_addr_i, ld_data_i};
  assign ld_wr     = 1'b0;
  assign ld_err_d  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Not cleared by reset: a loader strobe seen during reset must still flag an error.
  always_ff @(posedge clk_i) ld_err_q <= ld_err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    gnt     = (state_q == S_RUN) && (!valid_q || ready_i);
    accept  = req_i && gnt;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_RUN;
      end
      default: ;
    endcase
    if (accept)                valid_d = 1'b1;
    else if (valid_q && ready_i) valid_d = 1'b0;
  end

  assign we    = rst_ni && ((state_q == S_INIT) || ld_wr);
  assign waddr = (state_q == S_INIT) ? cnt_q : ld_addr_i;
  assign wdata = (state_q == S_INIT) ? WIDTH'(image_word(32'(cnt_q))) : ld_data_i;

  prog_mem_array #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (accept),
    .raddr_i (addr_i),
    .rdata_o (data_o)
  );

  assign gnt_o    = gnt;
  assign valid_o  = valid_q;
  assign busy_o   = (state_q == S_INIT);
  assign ld_err_o = ld_err_q;

endmodule

// File: tb/tb_prog_mem.sv
// Scoreboard bench for prog_mem: expected words are queued at accept and checked
// when the core side consumes them.
module tb_prog_mem;
  localparam int W  = 12;
  localparam int AW = 4;
  localparam int D  = 16;
`ifdef PROG_MEM_LOADER_EN
  localparam logic LDERR_EXP = 1'b1;
`else
  localparam logic LDERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, req, ready, ld_we;
  logic [AW-1:0] addr, ld_addr;
  logic [W-1:0]  ld_data;
  logic          gnt, valid, busy, ld_err;
  logic [W-1:0]  data;

  always #5 clk = ~clk;

  prog_mem #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .addr_i    (addr),
    .gnt_o     (gnt),
    .valid_o   (valid),
    .data_o    (data),
    .ready_i   (ready),
    .busy_o    (busy),
    .ld_we_i   (ld_we),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data),
    .ld_err_o  (ld_err)
  );

  logic [W-1:0] img [D] = '{12'hC00, 12'hD20, 12'h900, 12'h900, 12'hB00, 12'h900, 12'h900, 12'h500,
                            12'h900, 12'h900, 12'hA00, 12'h500, 12'h900, 12'h900, 12'hE00, 12'hC00};
  logic [W-1:0] model [D];
  logic [W-1:0] sb [$];
  int n_tot = 0;
  int n_bad = 0;
  int first_gnt, busy_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Call at the negedge: retire a consumed word, then queue the word for an accept.
  task automatic sample(input string tag);
    if (valid && ready) begin
      if (sb.size() == 0) chk({tag, "_unexpected_valid"}, 32'(sb.size()), 32'd1);
      else                chk(tag, data, sb.pop_front());
    end
    if (req && gnt) sb.push_back(model[addr]);
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    sample(tag);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 1'b0; ready = 1'b0; ld_we = 1'b0;
    addr = '0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    foreach (model[i]) model[i] = img[i];
  endtask

  task automatic wait_run();
    for (int c = 0; c < 40 && busy !== 1'b0; c++) begin
      @(posedge clk); #1;
    end
    chk("wait_run_busy", busy, 1'b0);
  endtask

  task automatic fetch(input logic [AW-1:0] a, input string tag);
    req = 1'b1; addr = a; ready = 1'b1;
    step(tag);
    req = 1'b0;
    step(tag);
  endtask

  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data, 12'h000);
    chk("rst_busy", busy, 1'b1);
    chk("rst_gnt", gnt, 1'b0);
    chk("rst_lderr", ld_err, 1'b0);
    @(posedge clk); #1;

    // init length and first fetch latency
    req = 1'b1; addr = 4'd1; ready = 1'b1; rst_n = 1'b1;
    first_gnt = -1; busy_cnt = 0;
    for (int c = 0; c < 40 && first_gnt < 0; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (gnt) first_gnt = c;
      else begin @(posedge clk); #1; end
    end
    chk("first_gnt_cycle", 32'(first_gnt), 32'd16);
    chk("busy_cycles", 32'(busy_cnt), 32'd16);
    sample("d20_accept");
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("d20_valid", valid, 1'b1);
    sample("d20_data");
    @(posedge clk); #1;

    // full-rate burst over every address
    req = 1'b1; ready = 1'b1;
    for (int a = 0; a < D; a++) begin
      addr = AW'(a);
      @(negedge clk);
      chk("burst_gnt", gnt, 1'b1);
      sample("burst_data");
      @(posedge clk); #1;
    end
    req = 1'b0;
    step("burst_tail");
    chk("burst_drained", 32'(sb.size()), 32'd0);

    // back-pressure: word frozen, no grant, reopen on consume
    req = 1'b1; addr = 4'd4; ready = 1'b0;
    step("bp_accept");
    addr = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", valid, 1'b1);
      chk("bp_data", data, 12'hB00);
      chk("bp_gnt", gnt, 1'b0);
      @(posedge clk); #1;
    end
    req = 1'b0; ready = 1'b1;
    @(negedge clk);
    chk("bp_gnt_reopen", gnt, 1'b1);
    sample("bp_consume");
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_valid_drop", valid, 1'b0);
    chk("bp_data_hold", data, 12'hB00);
    @(posedge clk); #1;

    // random request/ready traffic
    for (int i = 0; i < 60; i++) begin
      req = 1'($urandom); addr = AW'($urandom); ready = ($urandom_range(0, 3) != 0);
      step("rand_data");
    end
    req = 1'b0; ready = 1'b1;
    step("rand_tail");
    chk("rand_drained", 32'(sb.size()), 32'd0);

    // loader strobe during init is rejected
    do_reset();
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    ld_we = 1'b1; ld_addr = 4'd3; ld_data = 12'h777;
    @(posedge clk); #1;
    ld_we = 1'b0;
    @(negedge clk);
    chk("init_lderr_pulse", ld_err, LDERR_EXP);
    @(posedge clk); #1;
    @(negedge clk);
    chk("init_lderr_clear", ld_err, 1'b0);
    @(posedge clk); #1;
    wait_run();
    fetch(4'd3, "init_ld_dropped");

    // loader write colliding with a fetch of the same cell
    req = 1'b1; addr = 4'd3; ready = 1'b1;
    ld_we = 1'b1; ld_addr = 4'd3; ld_data = 12'h123;
    step("rbw_old");
`ifdef PROG_MEM_LOADER_EN
    model[3] = 12'h123;
`endif
    ld_we = 1'b0;
    step("rbw_new");
    req = 1'b0;
    @(negedge clk);
    chk("run_lderr", ld_err, 1'b0);
    sample("rbw_new_data");
    @(posedge clk); #1;

    // reset with a word in flight discards it and restores the image
    req = 1'b1; addr = 4'd3; ready = 1'b0;
    step("mid_accept");
    req = 1'b0;
    @(negedge clk);
    chk("mid_valid_before", valid, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_valid_after", valid, 1'b0);
    chk("mid_busy", busy, 1'b1);
    sb.delete();
    foreach (model[i]) model[i] = img[i];
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_run();
    fetch(4'd3, "mid_reimage");
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
